kernel_bc_write_back_ctrl: RTL and testbench

- Write-back process stage; consumes the 1-bit start token produced by the start_for_write_back FIFO.
- Per token: latches a job descriptor (base address, word count), drains that many result words from an upstream HLS-style FIFO, and writes them to memory as AXI4-style write bursts.
- Completion is signalled with ap_done.
- Sits between the compute pipeline's result FIFO and the kernel's memory write master.

---
 rtl/kernel_bc_write_back_ctrl.sv | 163 ++++++++++++++++
 tb/tb_kernel_bc_write_back_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_bc_write_back_ctrl.sv
// Write-back stage: pops a start token, latches a job descriptor and
// streams result-FIFO words to memory as single-outstanding write bursts.
module kernel_bc_write_back_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_empty_n,
    output logic                  start_read,
    input  logic                  start_dout,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  din_empty_n,
    output logic                  din_read,
    input  logic [DATA_WIDTH-1:0] din_dout,
    output logic                  mem_awvalid,
    input  logic                  mem_awready,
    output logic [ADDR_WIDTH-1:0] mem_awaddr,
    output logic [7:0]            mem_awlen,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wlast,
    input  logic                  mem_bvalid,
    output logic                  mem_bready,
    output logic                  ap_done,
    output logic                  ap_idle
);

    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] burst_bytes;
    logic                  w_fire;
    logic                  unused_ok;

    // The token payload carries no information for this stage.
    assign unused_ok = &{1'b0, start_dout};

    function automatic logic [7:0] burst_len(input logic [CNT_WIDTH-1:0] n);
        if (n >= CNT_WIDTH'(MAX_BURST)) begin
            return 8'(MAX_BURST - 1);
        end
        return 8'(n - CNT_WIDTH'(1));
    endfunction

    assign burst_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1))
                       * ADDR_WIDTH'(BYTES);
    assign w_fire = (state_q == S_W) && din_empty_n && mem_wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        beat_d      = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_empty_n) begin
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    len_d       = burst_len(num_words);
                    state_d     = (num_words == '0) ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                if (mem_awready) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_fire) begin
                    beat_d      = beat_q + 8'd1;
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (beat_q == len_q) begin
                        addr_d  = addr_q + burst_bytes;
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (mem_bvalid) begin
                    if (remaining_q != '0) begin
                        // Length is fixed here so awlen is stable through AW.
                        len_d   = burst_len(remaining_q);
                        state_d = S_AW;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_read  = 1'b0;
        din_read    = 1'b0;
        mem_awvalid = 1'b0;
        mem_awaddr  = '0;
        mem_awlen   = '0;
        mem_wvalid  = 1'b0;
        mem_wdata   = '0;
        mem_wlast   = 1'b0;
        mem_bready  = 1'b0;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                start_read = start_empty_n & ~reset;
                ap_idle    = 1'b1;
            end
            S_AW: begin
                mem_awvalid = 1'b1;
                mem_awaddr  = addr_q;
                mem_awlen   = len_q;
            end
            S_W: begin
                mem_wvalid = din_empty_n;
                mem_wdata  = din_dout;
                mem_wlast  = (beat_q == len_q);
                din_read   = din_empty_n & mem_wready;
            end
            S_B:     mem_bready = 1'b1;
            S_DONE:  ap_done = 1'b1;
            default: ap_idle = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_kernel_bc_write_back_ctrl.sv
// Scoreboard bench for kernel_bc_write_back_ctrl: modelled start/result
// FIFOs and memory slave, expected bursts/beats/dones queued per job.
module tb_kernel_bc_write_back_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_empty_n = 1'b0;
    logic        start_read;
    logic        start_dout = 1'b1;
    logic [63:0] base_addr = '0;
    logic [31:0] num_words = '0;
    logic        din_empty_n = 1'b0;
    logic        din_read;
    logic [31:0] din_dout = '0;
    logic        mem_awvalid;
    logic        mem_awready = 1'b1;
    logic [63:0] mem_awaddr;
    logic [7:0]  mem_awlen;
    logic        mem_wvalid;
    logic        mem_wready = 1'b1;
    logic [31:0] mem_wdata;
    logic        mem_wlast;
    logic        mem_bvalid = 1'b1;
    logic        mem_bready;
    logic        ap_done;
    logic        ap_idle;

    kernel_bc_write_back_ctrl dut (
        .clk(clk), .reset(reset),
        .start_empty_n(start_empty_n), .start_read(start_read),
        .start_dout(start_dout), .base_addr(base_addr),
        .num_words(num_words), .din_empty_n(din_empty_n),
        .din_read(din_read), .din_dout(din_dout),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
        .ap_done(ap_done), .ap_idle(ap_idle)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] base; logic [31:0] n; } tok_t;
    typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;

    tok_t tokq[$];
    logic [31:0] din_q[$];
    aw_t exp_aw[$];
    w_t  exp_w[$];
    int  exp_done = 0;

    int total = 0, bad = 0;
    int pops = 0, dones = 0, din_reads = 0, aw_fires = 0, w_fires = 0;
    bit bp = 0, gap = 0;
    bit prev_aw_wait = 0;
    logic [63:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        start_empty_n = (tokq.size() != 0);
        base_addr = start_empty_n ? tokq[0].base : 64'd0;
        num_words = start_empty_n ? tokq[0].n : 32'd0;
        din_empty_n = (din_q.size() != 0) && !gap;
        din_dout = (din_q.size() != 0) ? din_q[0] : 32'd0;
    endtask

    task automatic push_job(input logic [63:0] base, input int n,
                            input logic [31:0] seed);
        tok_t t;
        aw_t a;
        w_t w;
        int rem;
        logic [63:0] addr;
        t.base = base;
        t.n = n;
        tokq.push_back(t);
        rem = n;
        addr = base;
        while (rem > 0) begin
            a.addr = addr;
            a.len = (rem >= 16) ? 8'd15 : 8'(rem - 1);
            exp_aw.push_back(a);
            addr = addr + 64'd64;
            rem = rem - ((rem >= 16) ? 16 : rem);
        end
        for (int i = 0; i < n; i++) begin
            w.data = seed + 32'(i) * 32'h0101_0101;
            w.last = ((i % 16) == 15) || (i == n - 1);
            din_q.push_back(w.data);
            exp_w.push_back(w);
        end
        exp_done++;
        refresh();
    endtask

    // Memory slave, FIFO model and monitor share one cycle schedule.
    initial begin
        forever begin
            bit sf, df;
            aw_t a;
            w_t w;
            @(negedge clk);
            if (bp) begin
                mem_awready = ($urandom_range(0, 1) == 1);
                mem_wready = ($urandom_range(0, 2) != 0);
                mem_bvalid = ($urandom_range(0, 2) == 0);
                gap = ($urandom_range(0, 3) == 0);
            end else begin
                mem_awready = 1'b1;
                mem_wready = 1'b1;
                mem_bvalid = 1'b1;
                gap = 1'b0;
            end
            refresh();
            #4;
            sf = 0;
            df = 0;
            if (!reset) begin
                if (prev_aw_wait && mem_awvalid) begin
                    check("aw_addr_stable", mem_awaddr, prev_addr);
                    check("aw_len_stable", 64'(mem_awlen), 64'(prev_len));
                end
                prev_aw_wait = mem_awvalid && !mem_awready;
                prev_addr = mem_awaddr;
                prev_len = mem_awlen;
                if (mem_awvalid || mem_wvalid)
                    check("aw_w_excl", 64'(mem_awvalid && mem_wvalid), 64'd0);
                if (din_read || mem_wvalid) begin
                    check("din_read_hs", 64'(din_read),
                          64'(mem_wvalid && mem_wready));
                    check("din_read_ne", 64'(din_read && !din_empty_n), 64'd0);
                end
                if (mem_awvalid && mem_awready) begin
                    aw_fires++;
                    if (exp_aw.size() == 0) begin
                        check("aw_unexpected", 64'd1, 64'd0);
                    end else begin
                        a = exp_aw.pop_front();
                        check("awaddr", mem_awaddr, a.addr);
                        check("awlen", 64'(mem_awlen), 64'(a.len));
                    end
                end
                if (mem_wvalid && mem_wready) begin
                    w_fires++;
                    if (exp_w.size() == 0) begin
                        check("w_unexpected", 64'd1, 64'd0);
                    end else begin
                        w = exp_w.pop_front();
                        check("wdata", 64'(mem_wdata), 64'(w.data));
                        check("wlast", 64'(mem_wlast), 64'(w.last));
                    end
                end
                if (din_read) begin
                    din_reads++;
                    df = 1;
                end
                if (start_read) begin
                    check("start_after_done", 64'(pops), 64'(dones));
                    pops++;
                    sf = 1;
                end
                if (ap_done) begin
                    dones++;
                    if (exp_done == 0) check("done_unexpected", 64'd1, 64'd0);
                    else exp_done--;
                end
            end
            @(posedge clk);
            #1;
            if (sf && tokq.size() != 0) void'(tokq.pop_front());
            if (df && din_q.size() != 0) void'(din_q.pop_front());
            refresh();
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (tokq.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0
                && exp_done == 0 && ap_idle) begin
                ok = 1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_idle"}, 64'(ap_idle), 64'd1);
        check({name, "_zero"}, 64'({start_read, din_read, mem_awvalid,
              mem_wvalid, mem_wlast, mem_bready, ap_done}), 64'd0);
        check({name, "_addr"}, mem_awaddr | 64'(mem_awlen)
              | 64'(mem_wdata), 64'd0);
    endtask

    initial begin
        int d0, r0, a0, p0;
        bit hit;

        // 1: zero-length token queued while still in reset
        push_job(64'h2000, 0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        p0 = pops; d0 = dones; r0 = din_reads; a0 = aw_fires;
        reset = 1'b0;
        wait_idle("t1_drain");
        check("t1_pops", 64'(pops - p0), 64'd1);
        check("t1_dones", 64'(dones - d0), 64'd1);
        check("t1_reads", 64'(din_reads - r0), 64'd0);
        check("t1_aw", 64'(aw_fires - a0), 64'd0);
        check("t1_idle", 64'(ap_idle), 64'd1);

        // 2: one full burst
        d0 = dones; r0 = din_reads; a0 = aw_fires;
        push_job(64'h1000, 16, 32'hA000_0000);
        wait_idle("t2_drain");
        check("t2_reads", 64'(din_reads - r0), 64'd16);
        check("t2_aw", 64'(aw_fires - a0), 64'd1);
        check("t2_dones", 64'(dones - d0), 64'd1);

        // 3: 37 words -> 16/16/5
        r0 = din_reads; a0 = aw_fires;
        push_job(64'h1000, 37, 32'hB000_0000);
        wait_idle("t3_drain");
        check("t3_reads", 64'(din_reads - r0), 64'd37);
        check("t3_aw", 64'(aw_fires - a0), 64'd3);

        // 4: backpressure, FIFO gaps, address wrap
        bp = 1;
        r0 = din_reads;
        push_job(64'h4_0000, 50, 32'hC000_0000);
        wait_idle("t4a_drain");
        push_job(64'hFFFF_FFFF_FFFF_FFC0, 20, 32'hC100_0000);
        wait_idle("t4b_drain");
        check("t4_reads", 64'(din_reads - r0), 64'd70);

        // 5: back-to-back tokens
        bp = 0;
        d0 = dones;
        push_job(64'h3000, 5, 32'hD000_0000);
        push_job(64'h5000, 18, 32'hD100_0000);
        wait_idle("t5_drain");
        check("t5_dones", 64'(dones - d0), 64'd2);

        // 6: reset during beat 5 of a 16-beat burst
        push_job(64'h6000, 16, 32'hE000_0000);
        r0 = w_fires;
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #2;
            if (w_fires - r0 == 4) begin
                hit = 1;
                break;
            end
        end
        check("t6_reach_beat5", 64'(hit), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        tokq.delete();
        din_q.delete();
        exp_aw.delete();
        exp_w.delete();
        exp_done = 0;
        pops = 0;
        dones = 0;
        prev_aw_wait = 0;
        refresh();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        bp = 1;
        d0 = dones; r0 = din_reads;
        push_job(64'h7000, 21, 32'hF000_0000);
        wait_idle("t6_drain");
        check("t6_dones", 64'(dones - d0), 64'd1);
        check("t6_reads", 64'(din_reads - r0), 64'd21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
